// File: rtl/bcd_converter.sv
// Free-running 4-bit binary to 2-digit BCD converter using sequential double dabble.
// One conversion every 6 clocks: LOAD, four SHIFT steps, DONE (result published).
module bcd_converter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bin_in,
  output logic [7:0] bcd_out,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  bin, bin_d;
  logic [7:0]  bcd, bcd_d;
  logic [7:0]  bcd_out_d;
  logic [7:0]  bcd_adj;

  // Add-3 correction per nibble, evaluated independently before the shift.
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin;
    bcd_d     = bcd;
    bcd_out_d = bcd_out;
    case (state_q)
      LOAD: begin
        bin_d   = bin_in;
        bcd_d   = 8'h00;
        cnt_d   = 2'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[6:0], bin, 1'b0};
        cnt_d          = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        bcd_out_d = bcd;
        state_d   = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      bin     <= 4'h0;
      bcd     <= 8'h00;
      bcd_out <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin     <= bin_d;
      bcd     <= bcd_d;
      bcd_out <= bcd_out_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed plus random bench for bcd_converter: a phase-tracking model queues the
// expected BCD at each LOAD edge and retires it at the matching DONE edge.
module tb_bcd_converter;

  logic       clk;
  logic       rst;
  logic [3:0] bin_in;
  logic [7:0] bcd_out;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] hold_val;
  int         phase;

  bcd_converter dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .state_o (state_o)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input logic [3:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = (v >= 4'd10) ? 4'd1 : 4'd0;
    ones = (v >= 4'd10) ? (v - 4'd10) : v;
    return {tens, ones};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the edge, then compare 1 time unit later.
  task automatic tick();
    logic [3:0] sampled;
    logic       was_load;
    logic       was_done;
    was_load = 1'b0;
    was_done = 1'b0;
    sampled  = bin_in;
    @(posedge clk);
    if (rst) begin
      phase    = 0;
      hold_val = 8'h00;
      exp_q.delete();
    end else begin
      if (phase == 0) begin
        exp_q.push_back(to_bcd(sampled));
        was_load = 1'b1;
      end
      if (phase == 5) begin
        was_done = 1'b1;
        if (exp_q.size() > 0) hold_val = exp_q.pop_front();
        else begin
          checks++;
          errors++;
          $error("FAIL queue_underflow observed=empty expected=entry");
        end
      end
      phase = (phase == 5) ? 0 : phase + 1;
    end
    #1;
    chk("bcd_out", bcd_out, hold_val);
    if (was_load) begin
      chk("probe_bin_load", {4'h0, dut.bin}, {4'h0, sampled});
      chk("probe_bcd_load", dut.bcd, 8'h00);
    end
    if (!rst && phase == 5) chk("probe_bcd_final", dut.bcd, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
    if (was_done) chk("bcd_out_upper_zero", {5'b0, bcd_out[7:5]}, 8'h00);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    phase    = 0;
    hold_val = 8'h00;
    rst      = 1'b1;
    bin_in   = 4'd0;
    @(negedge clk);

    // Single reset pulse, output zero right after, still zero after next DONE
    tick();
    rst = 1'b0;
    ticks(6);

    // 10 -> 0x10 on 6th edge after release (checked inside tick at DONE)
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    bin_in = 4'd10;
    ticks(5);
    chk("pre_done_10", bcd_out, 8'h00);
    tick();
    chk("done_10", bcd_out, 8'h10);

    // 15 held 12 cycles
    bin_in = 4'd15;
    ticks(12);
    chk("hold_15", bcd_out, 8'h15);

    // Sweep all input values
    for (int v = 0; v < 16; v++) begin
      bin_in = v[3:0];
      ticks(12);
      chk("sweep", bcd_out, to_bcd(v[3:0]));
    end

    // Change input during SHIFT: old value completes first
    while (phase != 0) tick();
    bin_in = 4'd7;
    ticks(2);
    bin_in = 4'd12;
    ticks(4);
    chk("mid_shift_old", bcd_out, 8'h07);
    ticks(6);
    chk("mid_shift_new", bcd_out, 8'h12);

    // Reset during SHIFT discards partial result
    while (phase != 2) tick();
    rst = 1'b1;
    tick();
    chk("reset_mid_shift", bcd_out, 8'h00);
    rst = 1'b0;
    bin_in = 4'd11;
    ticks(6);
    chk("after_reset_11", bcd_out, 8'h11);

    // Holding reset keeps output at zero
    rst = 1'b1;
    ticks(8);
    chk("reset_hold", bcd_out, 8'h00);
    rst = 1'b0;

    // Random input changes at arbitrary cycles, occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) bin_in = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_converter.md
BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 bin_in  input  4  unsigned binary value to convert, 0..15.
REQ-005 bcd_out  output  8  registered BCD result; [7:4] tens digit, [3:0] ones digit.
REQ-006 The block SHALL keep internal registers named bin (4-bit working shift register) and bcd (8-bit BCD accumulator) so benches can probe them hierarchically.

Function
REQ-007 The block SHALL convert by sequential shift-add-3 (double dabble), free-running with no start or valid handshake.
REQ-008 The FSM SHALL have states LOAD, SHIFT and DONE, plus a 2-bit iteration counter used in SHIFT.
REQ-009 LOAD edge: bin <= bin_in, bcd <= 0, counter <= 0, go to SHIFT.
REQ-010 SHIFT edge, step 1: each bcd nibble >= 5 SHALL be incremented by 3 (nibbles checked independently, in parallel).
REQ-011 SHIFT edge, step 2: the adjusted {bcd, bin} SHALL be shifted left by 1, so bin[3] enters bcd[0] and bin[0] <= 0.
REQ-012 After SHIFT, counter increments; after the 4th SHIFT edge (counter = 3) the FSM SHALL go to DONE.
REQ-013 DONE edge: bcd_out <= bcd, go to LOAD.
REQ-014 The conversion period SHALL be exactly 6 clock cycles (LOAD, SHIFT x4, DONE), repeating continuously.
REQ-015 bcd_out SHALL reflect the bin_in value sampled at the LOAD edge, updated 5 edges after that edge.
REQ-016 bcd_out SHALL hold its value between DONE edges and never show intermediate values.
REQ-017 bin_in changes during SHIFT or DONE SHALL NOT affect the conversion in progress; the new value is taken at the next LOAD.
REQ-018 Result encoding: tens = 1 if value >= 10, else 0; ones = value mod 10; bcd_out[7:5] is always 0.
REQ-019 Adding 3 to a nibble SHALL never overflow the nibble (value <= 9 before the shift).

Reset
REQ-020 When rst = 1 at a rising edge: state <= LOAD, counter <= 0, bin <= 0, bcd <= 0, bcd_out <= 8'h00.
REQ-021 Reset has priority over all FSM activity, including mid-conversion; the partial result SHALL be discarded.
REQ-022 The first LOAD SHALL occur on the first rising edge with rst = 0.
REQ-023 Holding rst high SHALL keep bcd_out at 8'h00.

Verification
REQ-024 Pulse rst for 1 edge with bin_in = 0 -> bcd_out = 8'b0000_0000 immediately after the reset edge; the value stays 0 after the next DONE.
REQ-025 Release reset, hold bin_in = 10 -> on the 6th edge after release, bcd_out = 8'b0001_0000; bin/bcd probes show the shift sequence.
REQ-026 Change bin_in from 10 to 15 and hold for at least 12 cycles -> bcd_out = 8'b0001_0101; no other intermediate value appears on bcd_out.
REQ-027 Sweep bin_in 0..15, each held 12 cycles -> bcd_out matches REQ-018 for every value (e.g. 9 -> 0x09, 12 -> 0x12).
REQ-028 Change bin_in during SHIFT -> the following DONE outputs the value sampled at LOAD; the next period outputs the new value.
REQ-029 Assert rst during SHIFT -> bcd_out = 0x00 on that edge; the conversion restarts from LOAD with correct results afterward.
